ascon_perm_core: RTL and testbench

//  Owns the 320-bit Ascon state S_0..S_4 and runs the Ascon permutation on it, one round per clk.

---
 rtl/ascon_perm_core.sv | 175 +++++++++++++++++
 tb/tb_ascon_perm_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_core.sv
// rtl/ascon_perm_core.sv - Ascon 320-bit state register and one-round-per-clock permutation engine
module ascon_perm_core #(
    parameter logic [63:0] IV = 64'h80400c0600000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] reg0_128b,
    input  logic [127:0] reg1_128b,
    input  logic [2:0]   operation_mode,
    input  logic         operation_ready,
    input  logic         state_shift_en,
    input  logic [2:0]   state_shift_sel,
    input  logic         state_shift_lsb,
    output logic [63:0]  S_0_reg,
    output logic [63:0]  S_1_reg,
    output logic [63:0]  S_2_reg,
    output logic [63:0]  S_3_reg,
    output logic [63:0]  S_4_reg,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        ready_q;
    logic        start;
    logic [3:0]  rnd;
    logic [3:0]  rnd_start;
    logic        mode_round;
    logic        mode_init;
    logic        last_round;
    logic [7:0]  rc;

    // Round datapath: a* after input mixing, b* after chi, c* after output fixup, r* after linear layer
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] b0, b1, b2, b3, b4;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] r0, r1, r2, r3, r4;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    assign start      = operation_ready & ~ready_q;
    assign mode_init  = (operation_mode == 3'b100);
    assign last_round = (rnd == 4'd11);
    assign rc         = 8'hf0 - ({4'b0000, rnd} * 8'h0f);
    assign done       = (state == ST_DONE);

    // Decode the requested permutation into its first round index (12 - number of rounds)
    always_comb begin
        rnd_start  = 4'd0;
        mode_round = 1'b0;
        case (operation_mode)
            3'b001: begin rnd_start = 4'd0; mode_round = 1'b1; end
            3'b010: begin rnd_start = 4'd4; mode_round = 1'b1; end
            3'b011: begin rnd_start = 4'd6; mode_round = 1'b1; end
            default: begin rnd_start = 4'd0; mode_round = 1'b0; end
        endcase
    end

    // Constant addition folded into x2 before the x2 ^= x1 step
    assign a0 = S_0_reg ^ S_4_reg;
    assign a1 = S_1_reg;
    assign a2 = S_2_reg ^ {56'd0, rc} ^ S_1_reg;
    assign a3 = S_3_reg;
    assign a4 = S_4_reg ^ S_3_reg;

    assign b0 = a0 ^ (~a1 & a2);
    assign b1 = a1 ^ (~a2 & a3);
    assign b2 = a2 ^ (~a3 & a4);
    assign b3 = a3 ^ (~a4 & a0);
    assign b4 = a4 ^ (~a0 & a1);

    assign c0 = b0 ^ b4;
    assign c1 = b1 ^ b0;
    assign c2 = ~b2;
    assign c3 = b3 ^ b2;
    assign c4 = b4;

    assign r0 = c0 ^ ror64(c0, 19) ^ ror64(c0, 28);
    assign r1 = c1 ^ ror64(c1, 61) ^ ror64(c1, 39);
    assign r2 = c2 ^ ror64(c2, 1)  ^ ror64(c2, 6);
    assign r3 = c3 ^ ror64(c3, 10) ^ ror64(c3, 17);
    assign r4 = c4 ^ ror64(c4, 7)  ^ ror64(c4, 41);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: reserved/none modes leave the FSM idle even on a start edge
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start && mode_round) begin
                    state_nxt = ST_RUN;
                end else if (start && mode_init) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_RUN: begin
                if (last_round) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State words, round counter, busy flag and start-edge history
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            busy    <= 1'b0;
            rnd     <= 4'd0;
            S_0_reg <= 64'd0;
            S_1_reg <= 64'd0;
            S_2_reg <= 64'd0;
            S_3_reg <= 64'd0;
            S_4_reg <= 64'd0;
        end else begin
            ready_q <= operation_ready;
            case (state)
                ST_IDLE: begin
                    if (start && mode_round) begin
                        busy <= 1'b1;
                        rnd  <= rnd_start;
                    end else if (start && mode_init) begin
                        S_0_reg <= IV;
                        S_1_reg <= reg0_128b[127:64];
                        S_2_reg <= reg0_128b[63:0];
                        S_3_reg <= reg1_128b[127:64];
                        S_4_reg <= reg1_128b[63:0];
                    end else if (!start && state_shift_en) begin
                        // Any start edge, even an ignored mode, takes priority over a shift strobe
                        case (state_shift_sel)
                            3'd0: S_0_reg <= {S_0_reg[62:0], state_shift_lsb};
                            3'd1: S_1_reg <= {S_1_reg[62:0], state_shift_lsb};
                            3'd2: S_2_reg <= {S_2_reg[62:0], state_shift_lsb};
                            3'd3: S_3_reg <= {S_3_reg[62:0], state_shift_lsb};
                            3'd4: S_4_reg <= {S_4_reg[62:0], state_shift_lsb};
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    S_0_reg <= r0;
                    S_1_reg <= r1;
                    S_2_reg <= r2;
                    S_3_reg <= r3;
                    S_4_reg <= r4;
                    rnd     <= rnd + 4'd1;
                    if (last_round) begin
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_perm_core.sv
// tb/tb_ascon_perm_core.sv - directed scoreboard bench for ascon_perm_core
module tb_ascon_perm_core;

    localparam logic [63:0] IV = 64'h80400c0600000000;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] reg0_128b;
    logic [127:0] reg1_128b;
    logic [2:0]   operation_mode;
    logic         operation_ready;
    logic         state_shift_en;
    logic [2:0]   state_shift_sel;
    logic         state_shift_lsb;
    logic [63:0]  S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [63:0]  m [5];
    logic [319:0] exp_q [$];
    logic [319:0] dut_state;

    assign dut_state = {S_0_reg, S_1_reg, S_2_reg, S_3_reg, S_4_reg};

    ascon_perm_core #(.IV(IV)) dut (
        .clk             (clk),
        .rst             (rst),
        .reg0_128b       (reg0_128b),
        .reg1_128b       (reg1_128b),
        .operation_mode  (operation_mode),
        .operation_ready (operation_ready),
        .state_shift_en  (state_shift_en),
        .state_shift_sel (state_shift_sel),
        .state_shift_lsb (state_shift_lsb),
        .S_0_reg         (S_0_reg),
        .S_1_reg         (S_1_reg),
        .S_2_reg         (S_2_reg),
        .S_3_reg         (S_3_reg),
        .S_4_reg         (S_4_reg),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_n(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] model_state();
        return {m[0], m[1], m[2], m[3], m[4]};
    endfunction

    // Reference permutation written after the Ascon C reference implementation
    task automatic model_perm(input int nr);
        logic [63:0] t [5];
        for (int r = 12 - nr; r < 12; r++) begin
            m[2] ^= ((64'hf - 64'(r)) << 4) | 64'(r);
            m[0] ^= m[4];
            m[4] ^= m[3];
            m[2] ^= m[1];
            for (int i = 0; i < 5; i++) begin
                t[i] = m[i] ^ (~m[(i + 1) % 5] & m[(i + 2) % 5]);
            end
            t[1] ^= t[0];
            t[0] ^= t[4];
            t[3] ^= t[2];
            t[2] = ~t[2];
            m[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
            m[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
            m[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
            m[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
            m[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        end
    endtask

    // nr = 0 means INIT; disturb injects shift strobes and a ready toggle while running
    task automatic run_op(input logic [2:0] mode, input int nr, input string tag,
                          input bit disturb, input int hold);
        int lat;
        int bcnt;
        int extra;
        lat  = 0;
        bcnt = 0;
        extra = 0;
        if (nr == 0) begin
            m[0] = IV;
            m[1] = reg0_128b[127:64];
            m[2] = reg0_128b[63:0];
            m[3] = reg1_128b[127:64];
            m[4] = reg1_128b[63:0];
        end else begin
            model_perm(nr);
        end
        exp_q.push_back(model_state());
        operation_mode  = mode;
        operation_ready = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            state_shift_en  = disturb && (k <= 6);
            state_shift_sel = 3'((k - 1) % 5);
            state_shift_lsb = 1'b1;
            operation_ready = !(disturb && (k == 3));
            operation_mode  = disturb ? 3'b100 : mode;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        state_shift_en = 1'b0;
        operation_ready = 1'b1;
        chk_n({tag, " latency"}, lat, nr + 1);
        chk_n({tag, " busy cycles"}, bcnt, nr);
        if (exp_q.size() > 0) begin
            chk({tag, " state"}, dut_state, exp_q.pop_front());
        end
        for (int k = 0; k < hold; k++) begin
            step();
            if (done || busy) extra++;
        end
        chk_n({tag, " extra activity"}, extra, 0);
        operation_ready = 1'b0;
        step();
    endtask

    task automatic do_init(input string tag);
        run_op(3'b100, 0, tag, 1'b0, 2);
    endtask

    initial begin
        int act;
        rst = 1'b1;
        reg0_128b = 128'h000102030405060708090a0b0c0d0e0f;
        reg1_128b = 128'h000102030405060708090a0b0c0d0e0f;
        operation_mode  = 3'b000;
        operation_ready = 1'b0;
        state_shift_en  = 1'b0;
        state_shift_sel = 3'd0;
        state_shift_lsb = 1'b0;
        for (int i = 0; i < 5; i++) m[i] = 64'd0;
        step();
        step();
        chk("reset state", dut_state, 320'd0);
        chk_n("reset busy", int'(busy), 0);
        chk_n("reset done", int'(done), 0);
        rst = 1'b0;
        step();

        // Abort p12 with reset while round index 5 is pending
        operation_mode  = 3'b001;
        operation_ready = 1'b1;
        for (int k = 0; k < 6; k++) step();
        chk_n("p12 busy before abort", int'(busy), 1);
        rst = 1'b1;
        operation_ready = 1'b0;
        step();
        chk("abort state", dut_state, 320'd0);
        chk_n("abort busy", int'(busy), 0);
        chk_n("abort done", int'(done), 0);
        rst = 1'b0;
        act = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done || busy) act++;
        end
        chk_n("post abort activity", act, 0);

        // Shift loading
        for (int i = 0; i < 64; i++) begin
            state_shift_en = 1'b1; state_shift_sel = 3'd2; state_shift_lsb = 1'b1;
            step();
        end
        for (int i = 0; i < 64; i++) begin
            state_shift_en = 1'b1; state_shift_sel = 3'd4; state_shift_lsb = (i % 2 == 0);
            step();
        end
        state_shift_en = 1'b0;
        step();
        chk("shift load", dut_state,
            {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA});
        state_shift_en = 1'b1; state_shift_sel = 3'd6; state_shift_lsb = 1'b1;
        step();
        state_shift_en = 1'b0;
        step();
        chk("shift sel 6 dropped", dut_state,
            {64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hAAAA_AAAA_AAAA_AAAA});

        // INIT load, then each permutation from the INIT state
        do_init("init");
        chk("init words", dut_state,
            {IV, 64'h0001020304050607, 64'h08090a0b0c0d0e0f, 64'h0001020304050607, 64'h08090a0b0c0d0e0f});
        run_op(3'b001, 12, "p12", 1'b0, 5);
        do_init("init2");
        run_op(3'b010, 8, "p8", 1'b0, 5);
        do_init("init3");
        run_op(3'b011, 6, "p6", 1'b0, 5);

        // INIT with a same-cycle shift strobe: the strobe must be dropped
        state_shift_en = 1'b1; state_shift_sel = 3'd0; state_shift_lsb = 1'b1;
        do_init("init with strobe");

        // p12 with strobes and a ready toggle while running
        run_op(3'b001, 12, "p12 disturbed", 1'b1, 10);

        // Reserved and none modes do nothing
        operation_mode = 3'b101;
        operation_ready = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done || busy) act++;
        end
        chk_n("mode 101 activity", act, 0);
        chk("mode 101 state", dut_state, model_state());
        operation_ready = 1'b0;
        step();
        operation_mode = 3'b000;
        operation_ready = 1'b1;
        act = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (done || busy) act++;
        end
        chk_n("mode 000 activity", act, 0);
        chk("mode 000 state", dut_state, model_state());
        operation_ready = 1'b0;
        step();

        // Ready held high for 50 cycles triggers a single p6
        run_op(3'b011, 6, "p6 held", 1'b0, 50);

        chk_n("scoreboard empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
